// File: rtl/axi8_lite_master_seq.sv
`default_nettype none
// ============================================================================
// Module   : axi8_lite_master_seq
// Purpose  : Command-driven AXI4-Lite master. Runs one complete single-beat
//            write (AW/W/B) or read (AR/R) per accepted command and returns
//            read data plus a status code (00 OK, 01 slave error, 10 timeout).
// Ports    : ACLK/ARESET       clock, async active-high reset
//            cmd_*             command request (valid/ready)
//            rsp_*             result (valid/ready), rdata and status
//            AW*/W*/B*         AXI-Lite write channels
//            AR*/R*            AXI-Lite read channels
// Revision : 1.0 - initial release
// ============================================================================
module axi8_lite_master_seq #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  // command port
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  // response port
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_status,
  // AXI write address / data / response
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic                    BVALID,
  output logic                    BREADY,
  input  logic [1:0]              BRESP,
  // AXI read address / data
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic                    RVALID,
  output logic                    RREADY,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP
);

  // Phase counter is at least 8 bits, wider only if TIMEOUT needs it.
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_SLVERR  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_AW_W = 3'd1,
    S_WR_B    = 3'd2,
    S_RD_AR   = 3'd3,
    S_RD_R    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                  state_q,   state_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q,  wvalid_d;
  logic                    bready_q,  bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q,  rready_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q,  awaddr_d;
  logic [ADDR_WIDTH-1:0]   araddr_q,  araddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q,   wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q,   rdata_d;
  logic [1:0]              status_q,  status_d;
  logic [CNT_W-1:0]        cnt_q,     cnt_d;

  logic                    phase_expired;
  logic                    aw_pending;
  logic                    w_pending;

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    status_d  = status_q;
    cnt_d     = cnt_q;

    // This is the last waiting cycle of the current phase.
    phase_expired = (cnt_q == CNT_LAST);
    // A channel is still pending if it is valid and not being taken this cycle.
    aw_pending    = awvalid_q & ~AWREADY;
    w_pending     = wvalid_q  & ~WREADY;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR_AW_W;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = S_RD_AR;
          end
        end
      end

      S_WR_AW_W: begin
        // AW and W retire independently; the phase ends when neither is left.
        awvalid_d = aw_pending;
        wvalid_d  = w_pending;
        if (!aw_pending && !w_pending) begin
          bready_d = 1'b1;
          state_d  = S_WR_B;
        end else if (phase_expired) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          rdata_d   = '0;
          status_d  = ST_TIMEOUT;
          state_d   = S_DONE;
        end
      end

      S_WR_B: begin
        if (BVALID) begin
          bready_d = 1'b0;
          rdata_d  = '0;
          status_d = (BRESP != 2'b00) ? ST_SLVERR : ST_OK;
          state_d  = S_DONE;
        end else if (phase_expired) begin
          bready_d = 1'b0;
          rdata_d  = '0;
          status_d = ST_TIMEOUT;
          state_d  = S_DONE;
        end
      end

      S_RD_AR: begin
        if (ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_R;
        end else if (phase_expired) begin
          arvalid_d = 1'b0;
          rdata_d   = '0;
          status_d  = ST_TIMEOUT;
          state_d   = S_DONE;
        end
      end

      S_RD_R: begin
        if (RVALID) begin
          rready_d = 1'b0;
          rdata_d  = RDATA;
          status_d = (RRESP != 2'b00) ? ST_SLVERR : ST_OK;
          state_d  = S_DONE;
        end else if (phase_expired) begin
          rready_d = 1'b0;
          rdata_d  = '0;
          status_d = ST_TIMEOUT;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d   = S_IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
      end
    endcase

    // Every state change restarts the phase counter, so each timed phase
    // starts from zero; it only advances while waiting in a timed phase.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == S_WR_AW_W || state_q == S_WR_B ||
                 state_q == S_RD_AR   || state_q == S_RD_R) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= S_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      status_q  <= ST_OK;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      status_q  <= status_d;
      cnt_q     <= cnt_d;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_DONE);
  assign rsp_rdata  = rdata_q;
  assign rsp_status = status_q;

  assign AWADDR  = awaddr_q;
  assign AWVALID = awvalid_q;
  assign WDATA   = wdata_q;
  assign WSTRB   = '1;
  assign WVALID  = wvalid_q;
  assign BREADY  = bready_q;
  assign ARADDR  = araddr_q;
  assign ARVALID = arvalid_q;
  assign RREADY  = rready_q;

endmodule
`default_nettype wire
